rej_sampler: RTL
================

# rej_sampler

- Consumes the squeezed SHAKE128 byte string produced by `sponge_const` for a public-matrix seed (domain 4'b1111, 5376 output bits).
- Parses the string into one uniform polynomial in NTT domain using Kyber rejection sampling: 12-bit candidates, keep those below q = 3329.
- Sits between the sponge and the matrix-vector multiply stage, on the reading end of the sponge's `output_string`/`done` interface.

## Interface
Parameters:
- `IN_BITS`, 5376, width of the squeezed string (672 bytes).
- `N`, 256, coefficients per polynomial.
- `Q`, 3329, rejection bound.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  start request; sampled in IDLE.
- `in`  in  IN_BITS  squeezed string; byte i = `in[8*i +: 8]` (SHAKE byte 0 at LSB).
- `in_valid`  in  1  connected to the sponge's `done`; `in` is stable while high.
- `poly_out`  out  N*12  coefficient k at `poly_out[12*k +: 12]`.
- `done`  out  1  polynomial complete; held until the next start or reset.
- `exhausted`  out  1  input ran out before N coefficients were accepted; held.
- `busy`  out  1  high in LOAD and SAMPLE.

## Operation
States and transitions:
- IDLE -> LOAD when `enable && in_valid`.
- LOAD: capture `in` into an internal shift buffer; clear the count and `poly_out`; clear `done` and `exhausted`. Next state SAMPLE.
- SAMPLE: consume one 3-byte triple per cycle (b0, b1, b2 = the lowest three unconsumed bytes), then shift the buffer right by 24 bits.
  - d1 = b0 + 256*(b1 & 0xF)
  - d2 = (b1 >> 4) + 16*b2
  - Both are 12-bit, unsigned compare.
- Acceptance order within a triple is d1 then d2:
  - d1 < Q is written at index `count`.
  - d2 < Q is written at `count` if d1 was rejected, otherwise at `count+1`.
  - `count` advances by the number written (0, 1 or 2).
- Last-slot rule: if `count == N-1` and both candidates are valid, write only d1 and discard d2.
- SAMPLE -> DONE when `count` reaches N.
- SAMPLE -> EXHAUSTED when all 224 triples are consumed with `count < N`. Coefficients written so far stay visible; the unwritten ones read 0.
- DONE and EXHAUSTED -> LOAD on `enable && in_valid`, otherwise hold.
- Arithmetic: `count` is 9 bits (range 0..256); the triple counter is 8 bits (range 0..224).

## Timing
- Reset values: all outputs 0; state IDLE.
- Reset asserted mid-operation clears everything immediately, with no partial `done`.
- Latency from the accepting `enable` edge:
  - 1 cycle in LOAD, then one cycle per triple.
  - `done` rises on the edge that writes coefficient N-1.
  - Minimum latency is 129 cycles (all candidates accepted); maximum before `exhausted` is 225 cycles.
- `poly_out[k]` is valid from the edge that writes it. Consumers use it only after `done`.
- `enable` while `busy` is ignored. `enable` without `in_valid` is ignored.
- `busy` is high from the LOAD cycle through the cycle that sets `done`/`exhausted`, then falls on the next edge.

## Configuration
- `REJ_SAMPLER_STATS_EN` defined:
  - Adds output `rejected_cnt` [8:0]: the number of candidates rejected, saturating at 511.
  - Adds output `triples_used` [7:0].
  - Both are cleared in LOAD and hold after DONE/EXHAUSTED.
- Undefined: these ports and their counters do not exist.

## Structure
- Shared package `kyber_pkg` holds:
  - `KYBER_Q` = 3329 and `KYBER_N` = 256.
  - `coeff_t` (logic [11:0]).
  - The sampler state enum.
  - `SHAKE_MATRIX_BITS` = 5376.
- One sub-module, `rej_parse3`: combinational triple-to-(d1, d2, v1, v2) decode. It is reused by the CBD/sampler variants.

## Test plan
- All-zero `in`, then `enable`:
  - All 256 coefficients are 0.
  - `done` rises 129 cycles after `enable` is sampled.
  - `exhausted` stays 0.
- All-0xFF `in`:
  - Every candidate equals 4095 and is rejected.
  - `exhausted` = 1 after 225 cycles, `done` = 0, `poly_out` = 0.
  - With STATS: `rejected_cnt` = 448.
- First triple 0x01, 0x23, 0x45, remainder zero:
  - coeff0 = 769, coeff1 = 1106.
  - `done` rises at cycle 129.
- Boundary triple 0x00, 0x0D, 0xD0 (d1 = 3328, d2 = 3328):
  - Both accepted.
  - Candidate 3329 (bytes 0x01, 0x0D, ...) is rejected and `count` does not advance for it.
- Crafted string with 255 accepted candidates, then a triple with two valid candidates 5 and 6:
  - coeff255 = 5; 6 is discarded.
  - `done` rises on that same cycle.
- `rst` pulled low at SAMPLE cycle 60, released, then restarted with the zero string:
  - Outputs are 0 during reset.
  - The second run completes normally with correct values.

Source files
------------

// File: rtl/kyber_pkg.sv
// Shared Kyber constants, coefficient type and rejection-sampler state encoding.
package kyber_pkg;

    localparam int unsigned KYBER_Q           = 3329;
    localparam int unsigned KYBER_N           = 256;
    localparam int unsigned SHAKE_MATRIX_BITS = 5376;

    typedef logic [11:0] coeff_t;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSample,
        StDone,
        StExhausted
    } rej_state_e;

endpackage

// File: rtl/rej_parse3.sv
// Combinational decode of one 3-byte triple into two 12-bit candidates and their
// below-Q flags.
module rej_parse3
    import kyber_pkg::*;
#(
    parameter int unsigned Q = KYBER_Q
) (
    input  logic [23:0] triple,
    output coeff_t      d1,
    output coeff_t      d2,
    output logic        v1,
    output logic        v2
);

    localparam coeff_t QC = coeff_t'(Q);

    // d1 = b0 | (b1 & 0xF) << 8, d2 = b1 >> 4 | b2 << 4: both are plain bit slices.
    assign d1 = triple[11:0];
    assign d2 = triple[23:12];
    assign v1 = (d1 < QC);
    assign v2 = (d2 < QC);

endmodule

// File: rtl/rej_sampler.sv
// Kyber uniform rejection sampler: parses a squeezed SHAKE128 string into one NTT-domain
// polynomial. Define REJ_SAMPLER_STATS_EN to add rejected_cnt / triples_used outputs.
module rej_sampler
    import kyber_pkg::*;
#(
    parameter int unsigned IN_BITS = SHAKE_MATRIX_BITS,
    parameter int unsigned N       = KYBER_N,
    parameter int unsigned Q       = KYBER_Q
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [IN_BITS-1:0]  in,
    input  logic                in_valid,
    output logic [N*12-1:0]     poly_out,
    output logic                done,
    output logic                exhausted,
    output logic                busy
`ifdef REJ_SAMPLER_STATS_EN
    ,
    output logic [8:0]          rejected_cnt,
    output logic [7:0]          triples_used
`endif
);

    localparam int unsigned TRIPLES = IN_BITS / 24;
    localparam logic [8:0]  CNT_LAST = 9'(N - 1);
    localparam logic [8:0]  CNT_FULL = 9'(N);
    localparam logic [7:0]  TRI_LAST = 8'(TRIPLES - 1);

    rej_state_e          state_q, state_d;
    logic [IN_BITS-1:0]  sbuf_q;
    logic [N*12-1:0]     poly_q;
    logic [8:0]          cnt_q, cnt_d;
    logic [7:0]          tri_q;
    logic                done_q, exh_q;

    coeff_t      d1, d2;
    logic        v1, v2;
    logic        w1, w2;
    int unsigned idx1, idx2;
    logic        start;

    rej_parse3 #(
        .Q (Q)
    ) u_parse (
        .triple (sbuf_q[23:0]),
        .d1     (d1),
        .d2     (d2),
        .v1     (v1),
        .v2     (v2)
    );

    assign start = enable && in_valid;

    always_comb begin
        w1   = v1;
        // With only one slot left a valid d2 behind a valid d1 has nowhere to go.
        w2   = v2 && !(v1 && (cnt_q == CNT_LAST));
        idx1 = 12 * int'(cnt_q);
        idx2 = v1 ? 12 * (int'(cnt_q) + 1) : idx1;
        cnt_d = cnt_q + {8'd0, w1} + {8'd0, w2};
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone, StExhausted: if (start) state_d = StLoad;
            StLoad:                      state_d = StSample;
            StSample: begin
                if (cnt_d == CNT_FULL)      state_d = StDone;
                else if (tri_q == TRI_LAST) state_d = StExhausted;
            end
            default:                     state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            sbuf_q  <= '0;
            poly_q  <= '0;
            cnt_q   <= '0;
            tri_q   <= '0;
            done_q  <= 1'b0;
            exh_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                StLoad: begin
                    sbuf_q <= in;
                    poly_q <= '0;
                    cnt_q  <= '0;
                    tri_q  <= '0;
                    done_q <= 1'b0;
                    exh_q  <= 1'b0;
                end
                StSample: begin
                    sbuf_q <= sbuf_q >> 24;
                    if (w1) poly_q[idx1 +: 12] <= d1;
                    if (w2) poly_q[idx2 +: 12] <= d2;
                    cnt_q  <= cnt_d;
                    tri_q  <= tri_q + 8'd1;
                    done_q <= (cnt_d == CNT_FULL);
                    exh_q  <= (cnt_d != CNT_FULL) && (tri_q == TRI_LAST);
                end
                default: ;
            endcase
        end
    end

    assign poly_out  = poly_q;
    assign done      = done_q;
    assign exhausted = exh_q;
    assign busy      = (state_q == StLoad) || (state_q == StSample);

`ifdef REJ_SAMPLER_STATS_EN
    logic [8:0] rej_q;
    logic [9:0] rej_sum;

    always_comb begin
        rej_sum = {1'b0, rej_q} + {9'd0, !v1} + {9'd0, !v2};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rej_q <= '0;
        end else if (state_q == StLoad) begin
            rej_q <= '0;
        end else if (state_q == StSample) begin
            rej_q <= rej_sum[9] ? 9'h1ff : rej_sum[8:0];
        end
    end

    assign rejected_cnt = rej_q;
    assign triples_used = tri_q;
`endif

endmodule
